// File: rtl/noc_ni_tx.sv
// Network-interface transmitter: packetizes core beats into head/body/tail flits on a credit-tracked VC.
// Latency 1 (beat accepted -> flit next cycle); in_ready drops when the chosen VC runs out of router credits.
module noc_ni_tx #(
  parameter int x_size     = 4,
  parameter int y_size     = 4,
  parameter int DATA_WIDTH = 64,
  parameter int FLIT_WIDTH = 80,
  parameter int VC_NUM     = 5,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [$clog2(x_size)-1:0] id_x,
  input  logic [$clog2(y_size)-1:0] id_y,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_last,
  input  logic [1:0]                in_dst_x,
  input  logic [1:0]                in_dst_y,
  output logic [FLIT_WIDTH-1:0]     flit_out,
  output logic                      flit_valid,
  input  logic [VC_NUM-1:0]         credit_in,
  output logic                      busy,
  output logic                      credit_err
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [4:0]            vc_oh;
    logic [1:0]            dst_y;
    logic [1:0]            dst_x;
    logic [4:0]            nxt_hop;
    logic [1:0]            ftype;
  } flit_t;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   credit [VC_NUM];
  logic [VW-1:0]   cur_vc_q, free_vc, sel_vc;
  logic            any_free;
  logic [1:0]      dst_x_q, dst_y_q, dx_sel, dy_sel, ftype;
  logic [4:0]      hop_q, hop_in, hop_sel;
  logic            accept;
  logic [VC_NUM-1:0] consume;
  flit_t           flit_d, flit_q;

  function automatic logic [4:0] xy_hop(input logic [7:0] ix, input logic [7:0] iy,
                                        input logic [7:0] dx, input logic [7:0] dy);
    if (dx > ix)      return 5'b00001;
    else if (dx < ix) return 5'b00010;
    else if (dy < iy) return 5'b00100;
    else if (dy > iy) return 5'b01000;
    else              return 5'b10000;
  endfunction

  assign hop_in = xy_hop(8'(id_x), 8'(id_y), 8'(in_dst_x), 8'(in_dst_y));

  // Lowest-index VC whose router buffer is completely drained.
  always_comb begin
    any_free = 1'b0;
    free_vc  = '0;
    for (int v = VC_NUM - 1; v >= 0; v--) begin
      if (credit[v] == FULL) begin
        any_free = 1'b1;
        free_vc  = VW'(v);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    sel_vc   = cur_vc_q;
    hop_sel  = hop_q;
    dx_sel   = dst_x_q;
    dy_sel   = dst_y_q;
    ftype    = 2'b00;
    case (state_q)
      IDLE: begin
        in_ready = any_free;
        sel_vc   = free_vc;
        hop_sel  = hop_in;
        dx_sel   = in_dst_x;
        dy_sel   = in_dst_y;
        ftype    = in_last ? 2'b11 : 2'b00;
        if (in_valid && any_free && !in_last) state_d = SEND;
      end
      SEND: begin
        in_ready = (credit[cur_vc_q] != '0);
        ftype    = in_last ? 2'b10 : 2'b01;
        if (in_valid && in_ready && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    flit_d.data    = in_data;
    flit_d.vc_oh   = 5'(5'd1 << sel_vc);
    flit_d.dst_y   = dy_sel;
    flit_d.dst_x   = dx_sel;
    flit_d.nxt_hop = hop_sel;
    flit_d.ftype   = ftype;
  end

  always_comb begin
    consume = '0;
    for (int v = 0; v < VC_NUM; v++) consume[v] = accept && (sel_vc == VW'(v));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_vc_q   <= '0;
      dst_x_q    <= '0;
      dst_y_q    <= '0;
      hop_q      <= '0;
      flit_q     <= '0;
      flit_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && state_q == IDLE) begin
        cur_vc_q <= free_vc;
        dst_x_q  <= in_dst_x;
        dst_y_q  <= in_dst_y;
        hop_q    <= hop_in;
      end
      flit_valid <= accept;
      flit_q     <= accept ? flit_d : '0;
    end
  end

  // A return and a consume on the same VC in one cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) credit[v] <= FULL;
      credit_err <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (credit_in[v] && !consume[v]) begin
          if (credit[v] == FULL) credit_err <= 1'b1;
          else                   credit[v] <= credit[v] + CW'(1);
        end else if (consume[v] && !credit_in[v]) begin
          credit[v] <= credit[v] - CW'(1);
        end
      end
    end
  end

  assign flit_out = flit_q;
  assign busy     = (state_q == SEND);

endmodule

// File: tb/tb_noc_ni_tx.sv
// Directed bench for noc_ni_tx: flit formatting, XY hop, VC choice, credit flow and reset behaviour.
module tb_noc_ni_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  id_x, id_y;
  logic        in_valid, in_ready, in_last;
  logic [63:0] in_data;
  logic [1:0]  in_dst_x, in_dst_y;
  logic [79:0] flit_out;
  logic        flit_valid;
  logic [4:0]  credit_in;
  logic        busy, credit_err;

  int n_chk  = 0;
  int n_pass = 0;

  noc_ni_tx dut (
    .clk        (clk),
    .rst        (rst),
    .id_x       (id_x),
    .id_y       (id_y),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_dst_x   (in_dst_x),
    .in_dst_y   (in_dst_y),
    .flit_out   (flit_out),
    .flit_valid (flit_valid),
    .credit_in  (credit_in),
    .busy       (busy),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [79:0] mk(input logic [1:0] t, input logic [4:0] hop,
                                     input logic [1:0] dx, input logic [1:0] dy,
                                     input logic [4:0] vc, input logic [63:0] d);
    return {d, vc, dy, dx, hop, t};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    credit_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d, input logic last, input logic [1:0] dx, input logic [1:0] dy);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_dst_x = dx;
    in_dst_y = dy;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    logic [1:0] t;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_dst_x = '0; in_dst_y = '0; credit_in = '0; id_x = '0; id_y = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_flit_valid", flit_valid, 0);
    check("rst_flit_out", flit_out, 0);
    check("rst_busy", busy, 0);
    check("rst_credit_err", credit_err, 0);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);

    // single-flit packet to the local port
    id_x = 2'd1; id_y = 2'd1;
    beat(64'hA5, 1'b1, 2'd1, 2'd1);
    check("single_valid", flit_valid, 1);
    check("single_flit", flit_out, mk(2'b11, 5'b10000, 2'd1, 2'd1, 5'b00001, 64'hA5));
    check("single_busy", busy, 0);
    @(posedge clk); #1;
    check("idle_valid", flit_valid, 0);
    check("idle_flit_zero", flit_out, 0);

    // three-beat packet, later beats carry junk dst that must be ignored
    do_reset();
    id_x = 2'd0; id_y = 2'd0;
    beat(64'h11, 1'b0, 2'd2, 2'd3);
    check("p3_head", flit_out, mk(2'b00, 5'b00001, 2'd2, 2'd3, 5'b00001, 64'h11));
    check("p3_busy_mid", busy, 1);
    beat(64'h22, 1'b0, 2'd0, 2'd0);
    check("p3_body", flit_out, mk(2'b01, 5'b00001, 2'd2, 2'd3, 5'b00001, 64'h22));
    beat(64'h33, 1'b1, 2'd1, 2'd1);
    check("p3_tail", flit_out, mk(2'b10, 5'b00001, 2'd2, 2'd3, 5'b00001, 64'h33));
    check("p3_busy_end", busy, 0);
    check("p3_credit0", dut.credit[0], 1);
    beat(64'h44, 1'b1, 2'd0, 2'd0);
    check("vc1_single", flit_out, mk(2'b11, 5'b10000, 2'd0, 2'd0, 5'b00010, 64'h44));

    // remaining hop directions from the centre of the mesh
    do_reset();
    id_x = 2'd2; id_y = 2'd2;
    beat(64'h55, 1'b1, 2'd1, 2'd3);
    check("hop_xminus", flit_out, mk(2'b11, 5'b00010, 2'd1, 2'd3, 5'b00001, 64'h55));
    beat(64'h66, 1'b1, 2'd2, 2'd1);
    check("hop_yminus", flit_out, mk(2'b11, 5'b00100, 2'd2, 2'd1, 5'b00010, 64'h66));
    beat(64'h77, 1'b1, 2'd2, 2'd3);
    check("hop_yplus", flit_out, mk(2'b11, 5'b01000, 2'd2, 2'd3, 5'b00100, 64'h77));

    // credit exhaustion on a 6-beat packet
    do_reset();
    id_x = 2'd0; id_y = 2'd0;
    for (int i = 0; i < 4; i++) begin
      t = (i == 0) ? 2'b00 : 2'b01;
      beat(64'(i + 1), 1'b0, 2'd3, 2'd0);
      check("bp_flit", flit_out, mk(t, 5'b00001, 2'd3, 2'd0, 5'b00001, 64'(i + 1)));
    end
    check("bp_in_ready", in_ready, 0);
    check("bp_busy", busy, 1);
    in_valid = 1'b1; in_data = 64'h5; in_last = 1'b0;
    @(posedge clk); #1;
    check("bp_stall", flit_valid, 0);
    credit_in = 5'b00001;
    @(posedge clk); #1;
    credit_in = '0;
    check("bp_stall_credit_edge", flit_valid, 0);
    check("bp_ready_after_credit", in_ready, 1);
    @(posedge clk); #1;
    check("bp_one_more", flit_out, mk(2'b01, 5'b00001, 2'd3, 2'd0, 5'b00001, 64'h5));
    check("bp_ready_again_low", in_ready, 0);
    @(posedge clk); #1;
    check("bp_no_extra", flit_valid, 0);
    in_valid = 1'b0;

    // simultaneous return+consume, then overflow on an idle VC
    do_reset();
    beat(64'h81, 1'b0, 2'd1, 2'd0);
    check("cr_credit0_head", dut.credit[0], 3);
    in_valid = 1'b1; in_data = 64'h82; in_last = 1'b0; credit_in = 5'b00101;
    @(posedge clk); #1;
    in_valid = 1'b0; credit_in = '0;
    check("cr_flit", flit_valid, 1);
    check("cr_credit0_same", dut.credit[0], 3);
    check("cr_credit2_hold", dut.credit[2], 4);
    check("cr_err_set", credit_err, 1);
    @(posedge clk); #1;
    check("cr_err_sticky", credit_err, 1);

    // asynchronous reset in the middle of a packet
    do_reset();
    check("rst_clears_err", credit_err, 0);
    beat(64'h91, 1'b0, 2'd3, 2'd3);
    check("mid_head_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", flit_valid, 0);
    check("mid_rst_flit", flit_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_credit0", dut.credit[0], 4);
    @(posedge clk); #1 rst = 1'b0;
    beat(64'h92, 1'b1, 2'd3, 2'd3);
    check("post_rst_single", flit_out, mk(2'b11, 5'b00001, 2'd3, 2'd3, 5'b00001, 64'h92));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/noc_ni_tx.md
NOC_NI_TX -- requirements
Module: noc_ni_tx

Interface
REQ-001 SHALL have parameter x_size, default 4, mesh width in routers.
REQ-002 SHALL have parameter y_size, default 4, mesh height in routers.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, payload bits per flit.
REQ-004 SHALL have parameter FLIT_WIDTH, default 80, flit width (DATA_WIDTH+16).
REQ-005 SHALL have parameter VC_NUM, default 5, virtual channels per router input port.
REQ-006 SHALL have parameter BUF_DEPTH, default 4, flit slots per VC in the attached router.
REQ-007 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port id_x, input, $clog2(x_size), X coordinate of the attached router.
REQ-010 SHALL have port id_y, input, $clog2(y_size), Y coordinate of the attached router.
REQ-011 SHALL have port in_valid, input, 1, core offers a payload beat.
REQ-012 SHALL have port in_ready, output, 1, beat accepted when in_valid && in_ready.
REQ-013 SHALL have port in_data, input, DATA_WIDTH, payload beat.
REQ-014 SHALL have port in_last, input, 1, beat is the final beat of its packet.
REQ-015 SHALL have port in_dst_x, input, 2, destination X; sampled only on a packet's first beat.
REQ-016 SHALL have port in_dst_y, input, 2, destination Y; sampled only on a packet's first beat.
REQ-017 SHALL have port flit_out, output, FLIT_WIDTH, flit to the router local_in.
REQ-018 SHALL have port flit_valid, output, 1, flit_out holds a valid flit this cycle.
REQ-019 SHALL have port credit_in, input, VC_NUM, one-cycle pulse per VC per freed router slot.
REQ-020 SHALL have port busy, output, 1, high while a packet is partially sent.
REQ-021 SHALL have port credit_err, output, 1, sticky credit-overflow flag.

Function
REQ-022 Flit layout SHALL be [1:0] type, [6:2] nxt_hop, [8:7] dst_x, [10:9] dst_y, [15:11] VCx one-hot, [79:16] data.
REQ-023 Type encoding SHALL be 00 head, 01 body, 10 tail, 11 single (head+tail in one flit).
REQ-024 nxt_hop SHALL be one-hot XY routing from id to dst: dst_x>id_x bit0 (X+); dst_x<id_x bit1 (X-); else dst_y<id_y bit2 (Y-); dst_y>id_y bit3 (Y+); equal bit4 (local).
REQ-025 One credit counter per VC, range 0..BUF_DEPTH, width $clog2(BUF_DEPTH+1).
REQ-026 FSM states SHALL be IDLE and SEND; reset state IDLE.
REQ-027 IDLE: in_ready=1 iff at least one VC has credit==BUF_DEPTH (fully drained).
REQ-028 IDLE accept: lowest-index fully drained VC is locked as cur_vc; dst latched; flit type single if in_last else head; next state SEND if !in_last else IDLE.
REQ-029 SEND: in_ready=1 iff credit[cur_vc]>0; accepted beat type body if !in_last else tail; tail returns FSM to IDLE.
REQ-030 In SEND, in_dst_x/in_dst_y SHALL be ignored; latched dst and nxt_hop used for all flits.
REQ-031 Each accepted beat SHALL produce exactly one flit with flit_valid=1 on the following cycle (latency 1); no beat dropped or duplicated.
REQ-032 flit_out SHALL be all-zero whenever flit_valid=0.
REQ-033 Each sent flit SHALL decrement credit[cur_vc] by 1 in the accept cycle.
REQ-034 credit_in[v] SHALL increment credit[v] by 1; simultaneous return and consume on same VC SHALL leave count unchanged.
REQ-035 credit_in[v] with credit[v]==BUF_DEPTH and no consume SHALL hold the count at BUF_DEPTH and set credit_err until reset.
REQ-036 in_ready SHALL depend only on state and registered credit counts (no combinational path from in_valid).
REQ-037 busy SHALL equal (state==SEND).
REQ-038 Beats of a packet SHALL never be interleaved with another packet; VC held from head to tail.

Reset
REQ-039 On rst=1, asynchronously: state IDLE, all credits BUF_DEPTH, flit_valid=0, flit_out=0, busy=0, credit_err=0, cur_vc and latched dst cleared.
REQ-040 Reset mid-packet SHALL abandon the packet; first beat after reset is treated as a new head.
REQ-041 in_ready SHALL be 1 in the first cycle after reset release (all VCs drained).

Verification
REQ-042 id=(1,1), one beat in_last=1, dst=(1,1), data=0xA5 -> next cycle flit_valid=1, type 11, nxt_hop 10000, VCx 00001, data 0xA5.
REQ-043 id=(0,0), 3-beat packet dst=(2,3) -> types 00,01,10 on 3 consecutive cycles, nxt_hop 00001, all on VC0; credit[0]=1 after.
REQ-044 BUF_DEPTH=4, 6-beat packet, no credits returned -> 4 flits sent, in_ready=0, busy=1; one credit_in[0] pulse -> exactly one more flit.
REQ-045 VC0 partially occupied (credit 2) then new head -> packet on VC1 (VCx 00010).
REQ-046 credit_in[0] pulse in same cycle as a VC0 flit accept -> credit[0] unchanged; credit_in[2] with credit[2]=4 -> credit_err=1, count stays 4.
REQ-047 rst asserted after head of 3-beat packet -> flit_valid=0, credits 4, busy=0 immediately; next beat emitted as head/single.
